multdiv_ctrl: RTL and testbench

Sequencer for the iterative multiply/divide unit in the execute stage. It detects a decoded `mult`/`div` in DX and freezes the front of the pipeline. It issues a one-cycle start to the multdiv datapath, waits for its ready (bounded by a watchdog), and retires the instruction through its own writeback port. On overflow, divide-by-zero or timeout it writes the exception code to `$r30`.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/md_watchdog.sv | 29 ++
 rtl/multdiv_ctrl.sv | 134 +++++++++++++
 tb/tb_multdiv_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: multdiv sequencer states, exception codes,
// the status register index and the decoder's aluop codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;
  localparam logic [4:0]  REG_RSTATUS = 5'd30;
  localparam logic [4:0]  ALU_MULT    = 5'b00110;
  localparam logic [4:0]  ALU_DIV     = 5'b00111;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? EXC_DIV : EXC_MULT;
  endfunction

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter bounding how long the sequencer waits on multdiv ready.
// expired is high while the count sits at LAT_LIMIT-1 (the last allowed cycle).
module md_watchdog #(
  parameter int LAT_LIMIT = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [6:0] EXPIRE_AT = 7'(LAT_LIMIT - 1);

  logic [6:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 7'd0;
    end else if (clear) begin
      r_count <= 7'd0;
    end else if (enable) begin
      r_count <= r_count + 7'd1;
    end
  end

  assign expired = (r_count == EXPIRE_AT);

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the iterative multiply/divide unit: freezes the
// front end, starts the datapath, waits (with watchdog) and retires via its own writeback.
//
// state | meaning
// IDLE  | waiting for a mult/div in DX; stall asserted combinationally on start
// ISSUE | one-cycle start pulse to the datapath, watchdog cleared
// BUSY  | waiting for md_ready or watchdog expiry; abort returns to IDLE
// DONE  | writeback cycle, DX squashed, front end released
module multdiv_ctrl
  import cpu_pkg::*;
#(
  parameter int LAT_LIMIT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        dx_valid,
  input  logic        dx_mult,
  input  logic        dx_div,
  input  logic [4:0]  dx_rd,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic        abort,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic        dx_squash,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  logic        r_is_div;
  logic [4:0]  r_rd;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic w_start;
  logic w_accept;
  logic w_capture;
  logic w_exc;
  logic w_expired;

  assign w_start  = dx_valid & (dx_mult | dx_div) & ~abort;
  assign w_accept = (r_state == ST_IDLE) & w_start;
  // Missing ready at capture time means the watchdog fired.
  assign w_exc    = ~md_ready | md_exception;

  md_watchdog #(
    .LAT_LIMIT(LAT_LIMIT)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (r_state == ST_ISSUE),
    .enable  (r_state == ST_BUSY),
    .expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = abort ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (md_ready || w_expired) begin
          w_state_nxt = ST_DONE;
          w_capture   = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_is_div  <= 1'b0;
      r_rd      <= 5'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= 32'd0;
    end else begin
      if (w_accept) begin
        r_is_div <= ~dx_mult;
        r_rd     <= dx_rd;
        r_a      <= dx_a;
        r_b      <= dx_b;
      end
      if (w_capture) begin
        r_wb_rd   <= w_exc ? REG_RSTATUS : r_rd;
        r_wb_data <= w_exc ? exc_code(r_is_div) : md_result;
      end
    end
  end

  assign md_ctrl_mult = (r_state == ST_ISSUE) & ~r_is_div;
  assign md_ctrl_div  = (r_state == ST_ISSUE) & r_is_div;
  assign md_a         = r_a;
  assign md_b         = r_b;
  assign stall        = w_accept | (r_state == ST_ISSUE) | (r_state == ST_BUSY);
  assign dx_squash    = (r_state == ST_DONE);
  assign wb_valid     = (r_state == ST_DONE);
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized bench for multdiv_ctrl against a transaction-level timing/result model.
module tb_multdiv_ctrl;

  localparam int L = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        dx_valid, dx_mult, dx_div, abort;
  logic [4:0]  dx_rd;
  logic [31:0] dx_a, dx_b;
  logic        md_ready, md_exception;
  logic [31:0] md_result;
  logic        md_ctrl_mult, md_ctrl_div, stall, dx_squash, wb_valid;
  logic [31:0] md_a, md_b, wb_data;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  multdiv_ctrl #(.LAT_LIMIT(L)) dut (
    .clock(clock), .reset_n(reset_n),
    .dx_valid(dx_valid), .dx_mult(dx_mult), .dx_div(dx_div), .dx_rd(dx_rd),
    .dx_a(dx_a), .dx_b(dx_b), .abort(abort),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_a(md_a), .md_b(md_b), .stall(stall), .dx_squash(dx_squash),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic to_next();
    @(posedge clock);
    #1;
  endtask

  task automatic junk_dx();
    dx_valid = 1'($urandom_range(0, 1));
    dx_mult  = 1'($urandom_range(0, 1));
    dx_div   = 1'($urandom_range(0, 1));
    dx_rd    = 5'($urandom);
    dx_a     = $urandom;
    dx_b     = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_mult"},  32'(md_ctrl_mult), 32'd0);
    check_val({tag, "_div"},   32'(md_ctrl_div),  32'd0);
    check_val({tag, "_a"},     md_a,              32'd0);
    check_val({tag, "_b"},     md_b,              32'd0);
    check_val({tag, "_stall"}, 32'(stall),        32'd0);
    check_val({tag, "_sq"},    32'(dx_squash),    32'd0);
    check_val({tag, "_wbv"},   32'(wb_valid),     32'd0);
    check_val({tag, "_wbrd"},  32'(wb_rd),        32'd0);
    check_val({tag, "_wbd"},   wb_data,           32'd0);
  endtask

  // Cycles in which no start is possible: every output except the operand/data
  // holding registers must stay quiet, whatever md_ready does.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      junk_dx();
      abort = 1'b0;
      case ($urandom_range(0, 2))
        0: dx_valid = 1'b0;
        1: abort = 1'b1;
        default: begin dx_mult = 1'b0; dx_div = 1'b0; end
      endcase
      md_ready     = 1'($urandom_range(0, 1));
      md_exception = 1'($urandom_range(0, 1));
      md_result    = $urandom;
      @(negedge clock);
      check_val("idle_stall", 32'(stall), 32'd0);
      check_val("idle_pulse", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
      check_val("idle_wbv",   32'(wb_valid), 32'd0);
      check_val("idle_sq",    32'(dx_squash), 32'd0);
      to_next();
    end
  endtask

  // One operation offered at relative cycle 0. k = BUSY cycle (1-based) in which
  // md_ready arrives, 0 = never. ra = relative cycle of abort, 0 = none.
  task automatic run_op(input logic op_m, input logic op_d, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input int k,
                        input logic exc, input logic [31:0] res, input int ra,
                        input logic rdy0);
    int   last_busy, done_r, end_r, rdy_r;
    bit   aborted, in_time;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    in_time   = (k != 0) && (k <= L);
    last_busy = 1 + (in_time ? k : L);
    aborted   = (ra != 0) && (ra <= last_busy);
    done_r    = last_busy + 1;
    end_r     = aborted ? ra : done_r;
    rdy_r     = (k != 0) ? 1 + k : -1;
    if (in_time && !exc) begin
      exp_rd = rd; exp_data = res;
    end else begin
      exp_rd = 5'd30; exp_data = op_m ? 32'd4 : 32'd5;
    end
    for (int r = 0; r <= end_r; r++) begin
      if (r == 0) begin
        dx_valid = 1'b1; dx_mult = op_m; dx_div = op_d;
        dx_rd = rd; dx_a = a; dx_b = b;
        abort = 1'b0; md_ready = rdy0;
      end else begin
        junk_dx();
        abort    = (r == ra);
        md_ready = (r == 1) ? 1'($urandom_range(0, 1)) : (r == rdy_r);
      end
      if (!aborted && r == done_r) begin
        dx_valid = 1'b1; dx_mult = 1'b1;
      end
      md_exception = (r == rdy_r) ? exc : 1'($urandom_range(0, 1));
      md_result    = (r == rdy_r) ? res : $urandom;
      @(negedge clock);
      check_val("stall",     32'(stall),        32'(aborted || r != done_r));
      check_val("ctrl_mult", 32'(md_ctrl_mult), 32'(r == 1 && op_m));
      check_val("ctrl_div",  32'(md_ctrl_div),  32'(r == 1 && !op_m));
      check_val("wb_valid",  32'(wb_valid),     32'(!aborted && r == done_r));
      check_val("dx_squash", 32'(dx_squash),    32'(!aborted && r == done_r));
      if (r >= 1) begin
        check_val("md_a", md_a, a);
        check_val("md_b", md_b, b);
      end
      if (!aborted && r == done_r) begin
        check_val("wb_rd",   32'(wb_rd), 32'(exp_rd));
        check_val("wb_data", wb_data,    exp_data);
      end
      to_next();
    end
    abort = 1'b0; dx_valid = 1'b0; md_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    dx_valid = 0; dx_mult = 0; dx_div = 0; dx_rd = 0; dx_a = 0; dx_b = 0;
    abort = 0; md_ready = 0; md_exception = 0; md_result = 0;
    #2;
    check_all_zero("rst");
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    to_next();
    idle_cycles(3);

    run_op(1'b1, 1'b0, 5'd3, 32'd7, 32'd6, 2, 1'b0, 32'd42, 0, 1'b0);
    run_op(1'b0, 1'b1, 5'd12, 32'd9, 32'd0, 3, 1'b1, 32'hdead, 0, 1'b0);
    run_op(1'b1, 1'b0, 5'd9, 32'd11, 32'd13, 0, 1'b0, 32'd0, 0, 1'b0);
    run_op(1'b1, 1'b0, 5'd4, 32'd2, 32'd3, 4, 1'b0, 32'd6, 4, 1'b0);
    run_op(1'b1, 1'b0, 5'd6, 32'd5, 32'd5, 1, 1'b0, 32'd25, 0, 1'b1);
    run_op(1'b1, 1'b1, 5'd5, 32'd8, 32'd2, 1, 1'b0, 32'd16, 0, 1'b0);
    run_op(1'b0, 1'b1, 5'd0, 32'd8, 32'd2, L, 1'b0, 32'd4, 0, 1'b0);

    // Asynchronous reset in the middle of BUSY.
    dx_valid = 1'b1; dx_mult = 1'b0; dx_div = 1'b1; dx_rd = 5'd7;
    dx_a = 32'h1234; dx_b = 32'h5678; abort = 1'b0; md_ready = 1'b0;
    to_next();
    dx_valid = 1'b0;
    to_next();
    to_next();
    #2 reset_n = 1'b0;
    #1 check_all_zero("arst");
    @(posedge clock);
    #3 reset_n = 1'b1;
    to_next();
    idle_cycles(12);

    for (int n = 0; n < 150; n++) begin
      logic m, d, e;
      int   k, ra;
      case ($urandom_range(0, 2))
        0: begin m = 1'b1; d = 1'b0; end
        1: begin m = 1'b0; d = 1'b1; end
        default: begin m = 1'b1; d = 1'b1; end
      endcase
      case ($urandom_range(0, 5))
        0: k = 0;
        1: k = L;
        2: k = L + 1;
        default: k = $urandom_range(1, L);
      endcase
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(2, L + 3) : 0;
      e  = ($urandom_range(0, 3) == 0);
      run_op(m, d, 5'($urandom), $urandom, $urandom, k, e, $urandom, ra,
             1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
